// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage in-order MIPS pipeline.
//
// Purpose:
//   Commits GPR writes from the memory stage, owns the CP0 registers
//   (Status, Cause, EPC, BadVAddr, Count, Compare), detects exceptions,
//   interrupts and ERET at commit, and redirects the whole pipeline.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   ws_allowin          always 1: WB never stalls
//   ms_to_ws_valid/bus  instruction from MEM (field map below)
//   ext_int_in[5:0]     level-sensitive hardware interrupt lines
//   rf_we/waddr/wdata   register-file write port
//   ws_to_ds_bus        {res_valid, dest, wdata} forwarding to decode
//   exc_flush/flush_pc  pipeline flush and redirect target
//   debug_wb_*          commit trace
//
// Configuration:
//   WB_CP0_TIMER_EN     when defined, Count/Compare and the timer
//                       interrupt (TI) exist; otherwise they read as 0.
module wb_stage #(
  parameter int          MS_TO_WS_BUS_WD = 122,
  parameter logic [31:0] EXC_ENTRY       = 32'hbfc00380
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ws_allowin,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [5:0]                 ext_int_in,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [37:0]                ws_to_ds_bus,
  output logic                       exc_flush,
  output logic [31:0]                flush_pc,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  logic                       ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ws_bus;

  // Bus fields
  logic        f_of, f_ades, f_adel_if, f_adel_ld, f_ri, f_bp;
  logic        f_flush, f_bd, f_eret, f_sysc, f_mfc0, f_mtc0, f_gpr_we;
  logic [31:0] f_badvaddr, f_result, f_pc;
  logic [2:0]  f_sel;
  logic [4:0]  f_rd, f_dest;

  assign f_of       = ws_bus[121];
  assign f_badvaddr = ws_bus[120:89];
  assign f_ades     = ws_bus[88];
  assign f_adel_if  = ws_bus[87];
  assign f_adel_ld  = ws_bus[86];
  assign f_ri       = ws_bus[85];
  assign f_bp       = ws_bus[84];
  assign f_flush    = ws_bus[83];
  assign f_bd       = ws_bus[82];
  assign f_eret     = ws_bus[81];
  assign f_sysc     = ws_bus[80];
  assign f_mfc0     = ws_bus[79];
  assign f_mtc0     = ws_bus[78];
  assign f_sel      = ws_bus[77:75];
  assign f_rd       = ws_bus[74:70];
  assign f_gpr_we   = ws_bus[69];
  assign f_dest     = ws_bus[68:64];
  assign f_result   = ws_bus[63:32];
  assign f_pc       = ws_bus[31:0];

  // CP0 state
  logic [7:0]  status_im;
  logic        status_exl, status_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic [31:0] epc, badvaddr;
  logic        timer_int;

  logic        live, int_pend, exc, any_flag, badv_exc;
  logic [4:0]  exc_code;
  logic        cp0_wr, wr_status, wr_cause, wr_epc;
  logic [31:0] status_rdata, cause_rdata, cp0_rdata;

  assign ws_allowin = 1'b1;

  // Pipeline register: WB is always ready, so valid simply follows MEM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      ws_bus   <= '0;
    end else begin
      ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid && ws_allowin) ws_bus <= ms_to_ws_bus;
    end
  end

  // A killed (flushed) instruction behaves as a bubble.
  assign live     = ws_valid & ~f_flush;
  assign int_pend = status_ie & ~status_exl &
                    (|({cause_ip_hw, cause_ip_sw} & status_im));
  assign any_flag = f_adel_if | f_ri | f_of | f_bp | f_sysc | f_adel_ld | f_ades;
  assign exc      = live & (int_pend | any_flag);

  // ExcCode selection, highest priority first. badv_exc marks the
  // address-error cases that also latch BadVAddr.
  always_comb begin
    exc_code = 5'h00;
    badv_exc = 1'b0;
    if (int_pend)       exc_code = 5'h00;
    else if (f_adel_if) begin exc_code = 5'h04; badv_exc = 1'b1; end
    else if (f_ri)      exc_code = 5'h0a;
    else if (f_of)      exc_code = 5'h0c;
    else if (f_bp)      exc_code = 5'h09;
    else if (f_sysc)    exc_code = 5'h08;
    else if (f_adel_ld) begin exc_code = 5'h04; badv_exc = 1'b1; end
    else if (f_ades)    begin exc_code = 5'h05; badv_exc = 1'b1; end
  end

  // MTC0 decode; the value to write travels in the result field.
  assign cp0_wr    = live & ~exc & f_mtc0 & (f_sel == 3'd0);
  assign wr_status = cp0_wr & (f_rd == 5'd12);
  assign wr_cause  = cp0_wr & (f_rd == 5'd13);
  assign wr_epc    = cp0_wr & (f_rd == 5'd14);

  // Status: EXL is set by any exception, cleared by ERET, else MTC0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_im  <= 8'h00;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (exc) begin
      status_exl <= 1'b1;
    end else if (live && f_eret) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= f_result[15:8];
      status_exl <= f_result[1];
      status_ie  <= f_result[0];
    end
  end

  // Cause: hardware IP bits are resampled every cycle; BD only updates
  // for the first exception (EXL=0), like EPC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_bd      <= 1'b0;
      cause_ip_hw   <= 6'h00;
      cause_ip_sw   <= 2'b00;
      cause_exccode <= 5'h00;
    end else begin
      cause_ip_hw <= {ext_int_in[5] | timer_int, ext_int_in[4:0]};
      if (exc) begin
        cause_exccode <= exc_code;
        if (!status_exl) cause_bd <= f_bd;
      end
      if (wr_cause) cause_ip_sw <= f_result[9:8];
    end
  end

  // EPC points at the branch for delay-slot faults; BadVAddr is only
  // written by address errors.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc      <= 32'h0;
      badvaddr <= 32'h0;
    end else begin
      if (exc && !status_exl) epc <= f_bd ? f_pc - 32'd4 : f_pc;
      else if (wr_epc)        epc <= f_result;
      if (exc && badv_exc)    badvaddr <= f_badvaddr;
    end
  end

`ifdef WB_CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        tick, wr_count, wr_compare;

  assign wr_count   = cp0_wr & (f_rd == 5'd9);
  assign wr_compare = cp0_wr & (f_rd == 5'd11);

  // Count advances every other cycle; TI sticks until Compare is written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick      <= 1'b0;
      count     <= 32'h0;
      compare   <= 32'h0;
      timer_int <= 1'b0;
    end else begin
      tick <= ~tick;
      if (wr_count)  count <= f_result;
      else if (tick) count <= count + 32'd1;
      if (wr_compare) begin
        compare   <= f_result;
        timer_int <= 1'b0;
      end else if (count == compare) begin
        timer_int <= 1'b1;
      end
    end
  end
`else
  assign timer_int = 1'b0;
`endif

  assign status_rdata = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_rdata  = {cause_bd, timer_int, 14'b0, cause_ip_hw, cause_ip_sw,
                         1'b0, cause_exccode, 2'b0};

  // MFC0 read mux; unimplemented or sel!=0 reads return 0.
  always_comb begin
    cp0_rdata = 32'h0;
    if (f_sel == 3'd0) begin
      case (f_rd)
        5'd8:  cp0_rdata = badvaddr;
`ifdef WB_CP0_TIMER_EN
        5'd9:  cp0_rdata = count;
        5'd11: cp0_rdata = compare;
`endif
        5'd12: cp0_rdata = status_rdata;
        5'd13: cp0_rdata = cause_rdata;
        5'd14: cp0_rdata = epc;
        default: cp0_rdata = 32'h0;
      endcase
    end
  end

  assign rf_we        = live & f_gpr_we & ~exc;
  assign rf_waddr     = f_dest;
  assign rf_wdata     = f_mfc0 ? cp0_rdata : f_result;
  assign ws_to_ds_bus = rf_we ? {1'b1, f_dest, rf_wdata} : 38'h0;

  assign exc_flush = exc | (live & f_eret);
  assign flush_pc  = exc ? EXC_ENTRY : ((live & f_eret) ? epc : 32'h0);

  assign debug_wb_pc       = ws_valid ? f_pc : 32'h0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = f_dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
// CP0 state is observed through MFC0 instructions committed to the
// register file. Define WB_CP0_TIMER_EN to exercise the timer.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [121:0] ms_to_ws_bus;
  logic [5:0]   ext_int_in;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [37:0]  ws_to_ds_bus;
  logic         exc_flush;
  logic [31:0]  flush_pc;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  int total = 0;
  int bad   = 0;

  localparam int B_OF = 121, B_ADES = 88, B_ADEL_IF = 87, B_ADEL_LD = 86;
  localparam int B_RI = 85, B_BP = 84, B_FLUSH = 83, B_BD = 82;
  localparam int B_ERET = 81, B_SYSC = 80, B_MFC0 = 79, B_MTC0 = 78;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ext_int_in        (ext_int_in),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_to_ds_bus      (ws_to_ds_bus),
    .exc_flush         (exc_flush),
    .flush_pc          (flush_pc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  function automatic logic [121:0] mk(input logic [31:0] pc, input logic [31:0] res,
                                      input logic [4:0] dest, input logic we);
    logic [121:0] b;
    b = '0;
    b[31:0]  = pc;
    b[63:32] = res;
    b[68:64] = dest;
    b[69]    = we;
    return b;
  endfunction

  // Present one instruction for exactly one cycle; returns #1 after the
  // edge that loaded it, while it sits in WB.
  task automatic send(input logic [121:0] b);
    @(negedge clk);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = b;
    @(posedge clk);
    #1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
  endtask

  task automatic rd_cp0(input logic [4:0] r, input logic [2:0] s, output logic [31:0] v);
    logic [121:0] b;
    b = mk(32'h200, 32'h0, 5'd2, 1'b1);
    b[B_MFC0]  = 1'b1;
    b[74:70]   = r;
    b[77:75]   = s;
    send(b);
    v = rf_wdata;
  endtask

  task automatic wr_cp0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    logic [121:0] b;
    b = mk(32'h204, d, 5'd0, 1'b0);
    b[B_MTC0]  = 1'b1;
    b[74:70]   = r;
    b[77:75]   = s;
    send(b);
  endtask

  task automatic do_eret(input logic [31:0] want_pc);
    logic [121:0] b;
    b = mk(32'h300, 32'h0, 5'd0, 1'b0);
    b[B_ERET] = 1'b1;
    send(b);
    total++;
    if (exc_flush !== 1'b1) begin bad++; $display("[TB] FAIL eret_flush: got %b want 1", exc_flush); end
    total++;
    if (flush_pc !== want_pc) begin bad++; $display("[TB] FAIL eret_pc: got %h want %h", flush_pc, want_pc); end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rf_we, exc_flush, debug_wb_pc, ws_to_ds_bus, rf_wdata} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs: rf_we=%b flush=%b pc=%h fwd=%h", rf_we, exc_flush, debug_wb_pc, ws_to_ds_bus);
    end
    @(negedge clk);
    resetn = 1'b1;
    rd_cp0(5'd12, 3'd0, v);
    total++;
    if (v !== 32'h0040_0000) begin bad++; $display("[TB] FAIL reset_status: got %h want 00400000", v); end
    rd_cp0(5'd14, 3'd0, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL reset_epc: got %h want 0", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
`ifdef WB_CP0_TIMER_EN
    wr_cp0(5'd11, 3'd0, 32'd10);
    wr_cp0(5'd9,  3'd0, 32'd0);
    wr_cp0(5'd12, 3'd0, 32'h0000_8001);
    repeat (40) @(posedge clk);
    send(mk(32'h400, 32'h55, 5'd3, 1'b1));
    total++;
    if (exc_flush !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("[TB] FAIL timer_int: flush=%b rf_we=%b want 1/0", exc_flush, rf_we);
    end
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h4000_8000) begin bad++; $display("[TB] FAIL timer_cause: got %h want 40008000", v); end
    wr_cp0(5'd11, 3'd0, 32'h0000_1000);
    repeat (2) @(posedge clk);
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL timer_ti_clear: got %h want 0", v); end
    rd_cp0(5'd11, 3'd0, v);
    total++;
    if (v !== 32'h0000_1000) begin bad++; $display("[TB] FAIL timer_compare: got %h want 1000", v); end
    wr_cp0(5'd12, 3'd0, 32'h0);
`else
    wr_cp0(5'd11, 3'd0, 32'd10);
    wr_cp0(5'd9,  3'd0, 32'd7);
    rd_cp0(5'd11, 3'd0, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL notimer_compare: got %h want 0", v); end
    rd_cp0(5'd9, 3'd0, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL notimer_count: got %h want 0", v); end
`endif
    rd_cp0(5'd12, 3'd0, v);
    total++;
    if (v !== 32'h0040_0000) begin bad++; $display("[TB] FAIL timer_status: got %h want 00400000", v); end
  endtask

  task automatic test_alu();
    send(mk(32'hbfc0_0000, 32'h1234, 5'd5, 1'b1));
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      bad++; $display("[TB] FAIL alu_write: we=%b addr=%0d data=%h want 1/5/1234", rf_we, rf_waddr, rf_wdata);
    end
    total++;
    if (ws_to_ds_bus !== 38'h25_0000_1234) begin bad++; $display("[TB] FAIL alu_fwd: got %h want 2500001234", ws_to_ds_bus); end
    total++;
    if (exc_flush !== 1'b0 || debug_wb_rf_wen !== 4'hf || debug_wb_pc !== 32'hbfc0_0000) begin
      bad++; $display("[TB] FAIL alu_trace: flush=%b wen=%h pc=%h", exc_flush, debug_wb_rf_wen, debug_wb_pc);
    end
  endtask

  task automatic test_syscall();
    logic [121:0] b;
    logic [31:0]  v;
    b = mk(32'hbfc0_0100, 32'h99, 5'd4, 1'b1);
    b[B_SYSC] = 1'b1;
    send(b);
    total++;
    if (exc_flush !== 1'b1 || flush_pc !== 32'hbfc0_0380 || rf_we !== 1'b0) begin
      bad++; $display("[TB] FAIL sysc_flush: flush=%b pc=%h we=%b want 1/bfc00380/0", exc_flush, flush_pc, rf_we);
    end
    rd_cp0(5'd14, 3'd0, v);
    total++;
    if (v !== 32'hbfc0_0100) begin bad++; $display("[TB] FAIL sysc_epc: got %h want bfc00100", v); end
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h0000_0020) begin bad++; $display("[TB] FAIL sysc_cause: got %h want 00000020", v); end
    rd_cp0(5'd12, 3'd0, v);
    total++;
    if (v !== 32'h0040_0002) begin bad++; $display("[TB] FAIL sysc_status: got %h want 00400002", v); end
    do_eret(32'hbfc0_0100);
  endtask

  task automatic test_adel_ld();
    logic [121:0] b;
    logic [31:0]  v;
    b = mk(32'h80, 32'h0, 5'd6, 1'b1);
    b[B_ADEL_LD] = 1'b1;
    b[B_BD]      = 1'b1;
    b[120:89]    = 32'h1003;
    send(b);
    total++;
    if (exc_flush !== 1'b1 || flush_pc !== 32'hbfc0_0380) begin
      bad++; $display("[TB] FAIL adel_flush: flush=%b pc=%h", exc_flush, flush_pc);
    end
    rd_cp0(5'd14, 3'd0, v);
    total++;
    if (v !== 32'h7c) begin bad++; $display("[TB] FAIL adel_epc: got %h want 0000007c", v); end
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h8000_0010) begin bad++; $display("[TB] FAIL adel_cause: got %h want 80000010", v); end
    rd_cp0(5'd8, 3'd0, v);
    total++;
    if (v !== 32'h1003) begin bad++; $display("[TB] FAIL adel_badv: got %h want 00001003", v); end
    do_eret(32'h7c);
    rd_cp0(5'd12, 3'd0, v);
    total++;
    if (v !== 32'h0040_0000) begin bad++; $display("[TB] FAIL adel_exl_clr: got %h want 00400000", v); end
  endtask

  task automatic test_priority();
    logic [121:0] b;
    logic [31:0]  v;
    b = mk(32'h100, 32'h0, 5'd7, 1'b1);
    b[B_RI] = 1'b1;
    b[B_OF] = 1'b1;
    send(b);
    total++;
    if (exc_flush !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("[TB] FAIL prio_ri_flush: flush=%b we=%b", exc_flush, rf_we); end
    // Killed younger instruction: must look like a bubble but still trace.
    b = mk(32'h104, 32'h77, 5'd8, 1'b1);
    b[B_FLUSH] = 1'b1;
    b[B_SYSC]  = 1'b1;
    send(b);
    total++;
    if (rf_we !== 1'b0 || exc_flush !== 1'b0 || debug_wb_pc !== 32'h104) begin
      bad++; $display("[TB] FAIL flushed_inst: we=%b flush=%b pc=%h want 0/0/104", rf_we, exc_flush, debug_wb_pc);
    end
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h0000_0028) begin bad++; $display("[TB] FAIL prio_ri_cause: got %h want 00000028", v); end
    b = mk(32'h108, 32'h0, 5'd0, 1'b0);
    b[B_BP] = 1'b1; b[B_SYSC] = 1'b1; b[B_ADEL_LD] = 1'b1;
    b[120:89] = 32'hdead;
    send(b);
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h0000_0024) begin bad++; $display("[TB] FAIL prio_bp_cause: got %h want 00000024", v); end
    rd_cp0(5'd8, 3'd0, v);
    total++;
    if (v !== 32'h1003) begin bad++; $display("[TB] FAIL prio_bp_badv: got %h want 00001003", v); end
    b = mk(32'h10c, 32'h0, 5'd0, 1'b0);
    b[B_ADEL_IF] = 1'b1; b[B_RI] = 1'b1; b[B_ADES] = 1'b1;
    b[120:89] = 32'h2002;
    send(b);
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h0000_0010) begin bad++; $display("[TB] FAIL prio_adelif_cause: got %h want 00000010", v); end
    rd_cp0(5'd8, 3'd0, v);
    total++;
    if (v !== 32'h2002) begin bad++; $display("[TB] FAIL prio_adelif_badv: got %h want 00002002", v); end
    rd_cp0(5'd14, 3'd0, v);
    total++;
    if (v !== 32'h100) begin bad++; $display("[TB] FAIL prio_epc_held: got %h want 00000100", v); end
    do_eret(32'h100);
  endtask

  task automatic test_ext_int();
    logic [31:0] v;
    ext_int_in = 6'b000100;
    wr_cp0(5'd12, 3'd0, 32'h0000_1001);
    send(mk(32'h500, 32'h1, 5'd9, 1'b1));
    total++;
    if (exc_flush !== 1'b1 || rf_we !== 1'b0 || flush_pc !== 32'hbfc0_0380) begin
      bad++; $display("[TB] FAIL ext_int_taken: flush=%b we=%b pc=%h", exc_flush, rf_we, flush_pc);
    end
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h0000_1000) begin bad++; $display("[TB] FAIL ext_int_cause: got %h want 00001000", v); end
    rd_cp0(5'd14, 3'd0, v);
    total++;
    if (v !== 32'h500) begin bad++; $display("[TB] FAIL ext_int_epc: got %h want 00000500", v); end
    ext_int_in = 6'b0;
    wr_cp0(5'd12, 3'd0, 32'h0);
  endtask

  task automatic test_mtc0();
    logic [31:0] v;
    wr_cp0(5'd14, 3'd0, 32'h1234_5678);
    rd_cp0(5'd14, 3'd0, v);
    total++;
    if (v !== 32'h1234_5678) begin bad++; $display("[TB] FAIL mtc0_epc: got %h want 12345678", v); end
    wr_cp0(5'd12, 3'd0, 32'hffff_ffff);
    rd_cp0(5'd12, 3'd0, v);
    total++;
    if (v !== 32'h0040_ff03) begin bad++; $display("[TB] FAIL mtc0_status_mask: got %h want 0040ff03", v); end
    wr_cp0(5'd12, 3'd0, 32'h0);
    wr_cp0(5'd13, 3'd0, 32'hffff_ffff);
    rd_cp0(5'd13, 3'd0, v);
    total++;
    if (v !== 32'h0000_0300) begin bad++; $display("[TB] FAIL mtc0_cause_mask: got %h want 00000300", v); end
    wr_cp0(5'd12, 3'd0, 32'h0000_0301);
    send(mk(32'h600, 32'h2, 5'd10, 1'b1));
    total++;
    if (exc_flush !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("[TB] FAIL sw_int_taken: flush=%b we=%b", exc_flush, rf_we); end
    wr_cp0(5'd13, 3'd0, 32'h0);
    wr_cp0(5'd12, 3'd0, 32'h0);
    wr_cp0(5'd8, 3'd0, 32'hffff_ffff);
    rd_cp0(5'd8, 3'd0, v);
    total++;
    if (v !== 32'h2002) begin bad++; $display("[TB] FAIL badv_readonly: got %h want 00002002", v); end
    wr_cp0(5'd14, 3'd1, 32'h0);
    rd_cp0(5'd14, 3'd0, v);
    total++;
    if (v !== 32'h600) begin bad++; $display("[TB] FAIL sel_ignored: got %h want 00000600", v); end
    rd_cp0(5'd14, 3'd1, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("[TB] FAIL sel_read_zero: got %h want 0", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    send(mk(32'h700, 32'habcd, 5'd11, 1'b1));
    total++;
    if (rf_we !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_we: got %b want 1", rf_we); end
    wr_cp0(5'd12, 3'd0, 32'h0000_ff00);
    @(negedge clk);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = mk(32'h704, 32'h1, 5'd12, 1'b1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({rf_we, exc_flush, debug_wb_pc, ws_to_ds_bus, rf_waddr, rf_wdata, debug_wb_rf_wen} !== '0) begin
      bad++; $display("[TB] FAIL async_reset: we=%b pc=%h fwd=%h addr=%0d", rf_we, debug_wb_pc, ws_to_ds_bus, rf_waddr);
    end
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    @(negedge clk);
    resetn = 1'b1;
    rd_cp0(5'd12, 3'd0, v);
    total++;
    if (v !== 32'h0040_0000) begin bad++; $display("[TB] FAIL post_reset_status: got %h want 00400000", v); end
  endtask

  initial begin
    resetn         = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    ext_int_in     = 6'b0;
    test_reset();
    test_timer();
    test_alu();
    test_syscall();
    test_adel_ld();
    test_priority();
    test_ext_int();
    test_mtc0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
